// File: rtl/if_fetch_unit_pkg.sv
// Shared types and constants for the instruction fetch stage.
// FQ_ENTRY_t is the fetch-queue record carried from fetch to dispatch.
package if_fetch_unit_pkg;

  localparam int unsigned FQ_DEPTH_DEFAULT = 4;
  localparam logic [31:0] NOOP             = 32'h47ff041f;

  typedef struct packed {
    logic [63:0] PC;
    logic [63:0] NPC;
    logic [31:0] inst;
  } FQ_ENTRY_t;

endpackage

// File: rtl/if_fetch_unit_fetch_queue.sv
// Circular FIFO of fetch entries. The caller gates enq/deq for legality;
// flush empties the queue and wins over enq/deq in the same cycle.
module fetch_queue
  import if_fetch_unit_pkg::*;
#(
  parameter int unsigned DEPTH = FQ_DEPTH_DEFAULT,
  localparam int unsigned PW   = $clog2(DEPTH),
  localparam int unsigned CW   = $clog2(DEPTH + 1)
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          enq,
  input  logic          deq,
  input  logic          flush,
  input  FQ_ENTRY_t     din,
  output FQ_ENTRY_t     head,
  output logic [CW-1:0] count,
  output logic          full,
  output logic          empty
);

  FQ_ENTRY_t     mem_q [DEPTH];
  logic [PW-1:0] head_q, head_d;
  logic [PW-1:0] tail_q, tail_d;
  logic [CW-1:0] count_q, count_d;

  // Pointers are exactly log2(DEPTH) wide so wrap-around is plain overflow.
  always_comb begin
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    if (flush) begin
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
    end else begin
      if (enq) tail_d = tail_q + PW'(1);
      if (deq) head_d = head_q + PW'(1);
      case ({enq, deq})
        2'b10:   count_d = count_q + CW'(1);
        2'b01:   count_d = count_q - CW'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  // Entry storage needs no reset: count_q alone decides what is valid.
  always_ff @(posedge clock) begin
    if (enq && !flush && !reset) mem_q[tail_q] <= din;
  end

  assign head  = mem_q[head_q];
  assign count = count_q;
  assign full  = (count_q == CW'(DEPTH));
  assign empty = (count_q == '0);

endmodule

// File: rtl/if_fetch_unit.sv
// Fetch stage: owns the fetch PC, picks the 32-bit word out of the cache line
// and feeds a small queue towards dispatch. Static not-taken prediction.
module if_fetch_unit
  import if_fetch_unit_pkg::*;
#(
  parameter int unsigned FQ_DEPTH = FQ_DEPTH_DEFAULT
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [63:0] Icache_data_out,
  input  logic        Icache_valid_out,
  input  logic        rollback_en,
  input  logic [63:0] target_pc,
  input  logic        dispatch_en,
  output logic [63:0] proc2Icache_addr,
  output logic        if_valid,
  output logic [31:0] if_inst,
  output logic [63:0] if_PC,
  output logic [63:0] if_NPC,
  output logic        fq_full
);

  localparam int unsigned CW = $clog2(FQ_DEPTH + 1);

  logic [63:0]   pc_q, pc_d;
  logic [31:0]   inst_sel;
  logic          enq, deq;
  FQ_ENTRY_t     fq_din, fq_head;
  logic [CW-1:0] fq_count;
  logic          fq_full_w, fq_empty;

  assign inst_sel = pc_q[2] ? Icache_data_out[63:32] : Icache_data_out[31:0];

  // A full queue may still accept when the head leaves in the same cycle.
  assign enq = Icache_valid_out && !rollback_en && (!fq_full_w || dispatch_en);
  assign deq = dispatch_en && !fq_empty && !rollback_en;

  always_comb begin
    fq_din.PC   = pc_q;
    fq_din.NPC  = pc_q + 64'd4;
    fq_din.inst = inst_sel;
  end

  always_comb begin
    pc_d = pc_q;
    if (rollback_en)
      pc_d = target_pc & ~64'h3;
    else if (enq)
      pc_d = pc_q + 64'd4;
  end

  always_ff @(posedge clock) begin
    if (reset) pc_q <= '0;
    else       pc_q <= pc_d;
  end

  fetch_queue #(
    .DEPTH (FQ_DEPTH)
  ) u_fetch_queue (
    .clock (clock),
    .reset (reset),
    .enq   (enq),
    .deq   (deq),
    .flush (rollback_en),
    .din   (fq_din),
    .head  (fq_head),
    .count (fq_count),
    .full  (fq_full_w),
    .empty (fq_empty)
  );

  assign proc2Icache_addr = {pc_q[63:3], 3'b000};
  assign if_valid         = (fq_count != '0);
  assign if_inst          = fq_empty ? NOOP  : fq_head.inst;
  assign if_PC            = fq_empty ? 64'd0 : fq_head.PC;
  assign if_NPC           = fq_empty ? 64'd0 : fq_head.NPC;
  assign fq_full          = fq_full_w;

endmodule

// File: tb/tb_if_fetch_unit.sv
// Bench for if_fetch_unit: hand-derived vector table for the directed
// scenarios, then random traffic against a queue-based reference model.
module tb_if_fetch_unit;
  import if_fetch_unit_pkg::*;

  localparam int DEPTH = 4;
  localparam logic [63:0] D  = 64'hAAAA_BBBB_CCCC_DDDD;
  localparam logic [31:0] CD = 32'hCCCC_DDDD;
  localparam logic [31:0] AB = 32'hAAAA_BBBB;

  logic        clock = 1'b0;
  logic        reset;
  logic [63:0] Icache_data_out;
  logic        Icache_valid_out;
  logic        rollback_en;
  logic [63:0] target_pc;
  logic        dispatch_en;
  logic [63:0] proc2Icache_addr;
  logic        if_valid;
  logic [31:0] if_inst;
  logic [63:0] if_PC;
  logic [63:0] if_NPC;
  logic        fq_full;

  always #5 clock = ~clock;

  if_fetch_unit #(.FQ_DEPTH(DEPTH)) dut (
    .clock            (clock),
    .reset            (reset),
    .Icache_data_out  (Icache_data_out),
    .Icache_valid_out (Icache_valid_out),
    .rollback_en      (rollback_en),
    .target_pc        (target_pc),
    .dispatch_en      (dispatch_en),
    .proc2Icache_addr (proc2Icache_addr),
    .if_valid         (if_valid),
    .if_inst          (if_inst),
    .if_PC            (if_PC),
    .if_NPC           (if_NPC),
    .fq_full          (fq_full)
  );

  int n_vec = 0;
  int n_err = 0;

  // Reference model: a list of fetched instructions plus the fetch PC.
  typedef struct {
    logic [63:0] pc;
    logic [63:0] npc;
    logic [31:0] inst;
  } m_entry_t;
  m_entry_t    mq[$];
  logic [63:0] m_pc = 64'd0;

  typedef struct {
    logic        rst, vld;
    logic [63:0] data;
    logic        rb;
    logic [63:0] tpc;
    logic        de;
    logic [63:0] e_addr;
    logic        e_valid;
    logic [31:0] e_inst;
    logic [63:0] e_pc, e_npc;
    logic        e_full;
  } vec_t;
  vec_t tbl[$];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
    end
  endtask

  task automatic model_step(input logic rst, input logic vld, input logic [63:0] data,
                            input logic rb, input logic [63:0] tpc, input logic de);
    bit do_enq, do_deq;
    m_entry_t e;
    if (rst) begin
      m_pc = 64'd0;
      mq.delete();
    end else if (rb) begin
      m_pc = {tpc[63:2], 2'b00};
      mq.delete();
    end else begin
      do_deq = de && (mq.size() != 0);
      do_enq = vld && (mq.size() < DEPTH || de);
      if (do_deq) void'(mq.pop_front());
      if (do_enq) begin
        e.pc   = m_pc;
        e.npc  = m_pc + 64'd4;
        e.inst = m_pc[2] ? data[63:32] : data[31:0];
        mq.push_back(e);
        m_pc = m_pc + 64'd4;
      end
    end
  endtask

  // One clock: drive, advance model at the edge, sample 1ns later.
  task automatic cycle(input logic rst, input logic vld, input logic [63:0] data,
                       input logic rb, input logic [63:0] tpc, input logic de);
    reset = rst; Icache_valid_out = vld; Icache_data_out = data;
    rollback_en = rb; target_pc = tpc; dispatch_en = de;
    @(posedge clock);
    model_step(rst, vld, data, rb, tpc, de);
    #1;
    chk("mdl_addr",  proc2Icache_addr, {m_pc[63:3], 3'b000});
    chk("mdl_valid", 64'(if_valid), 64'(mq.size() != 0));
    chk("mdl_inst",  64'(if_inst), (mq.size() != 0) ? 64'(mq[0].inst) : 64'(NOOP));
    chk("mdl_pc",    if_PC,  (mq.size() != 0) ? mq[0].pc  : 64'd0);
    chk("mdl_npc",   if_NPC, (mq.size() != 0) ? mq[0].npc : 64'd0);
    chk("mdl_full",  64'(fq_full), 64'(mq.size() == DEPTH));
  endtask

  function automatic vec_t mk(input logic rst, vld, input logic rb, input logic [63:0] tpc,
                              input logic de, input logic [63:0] e_addr, input logic e_valid,
                              input logic [31:0] e_inst, input logic [63:0] e_pc, e_npc,
                              input logic e_full);
    vec_t v;
    v.rst = rst; v.vld = vld; v.data = D; v.rb = rb; v.tpc = tpc; v.de = de;
    v.e_addr = e_addr; v.e_valid = e_valid; v.e_inst = e_inst;
    v.e_pc = e_pc; v.e_npc = e_npc; v.e_full = e_full;
    return v;
  endfunction

  initial begin
    // rst vld rb tpc de | addr valid inst pc npc full
    tbl.push_back(mk(1, 0, 0, 0, 0,         'h0,    0, NOOP, 'h0, 'h0, 0));
    // fill the queue with no dispatch
    tbl.push_back(mk(0, 1, 0, 0, 0,         'h0,    1, CD, 'h0, 'h4, 0));
    tbl.push_back(mk(0, 1, 0, 0, 0,         'h8,    1, CD, 'h0, 'h4, 0));
    tbl.push_back(mk(0, 1, 0, 0, 0,         'h8,    1, CD, 'h0, 'h4, 0));
    tbl.push_back(mk(0, 1, 0, 0, 0,         'h10,   1, CD, 'h0, 'h4, 1));
    tbl.push_back(mk(0, 1, 0, 0, 0,         'h10,   1, CD, 'h0, 'h4, 1));
    // full queue streaming: pop and push together
    tbl.push_back(mk(0, 1, 0, 0, 1,         'h10,   1, AB, 'h4, 'h8, 1));
    tbl.push_back(mk(0, 1, 0, 0, 1,         'h18,   1, CD, 'h8, 'hC, 1));
    tbl.push_back(mk(0, 1, 0, 0, 1,         'h18,   1, AB, 'hC, 'h10, 1));
    tbl.push_back(mk(0, 1, 0, 0, 1,         'h20,   1, CD, 'h10, 'h14, 1));
    // drain to 3, then rollback with valid and dispatch both high
    tbl.push_back(mk(0, 0, 0, 0, 1,         'h20,   1, AB, 'h14, 'h18, 0));
    tbl.push_back(mk(0, 1, 1, 'h1003, 1,    'h1000, 0, NOOP, 'h0, 'h0, 0));
    // dispatch on empty queue, then fetch low and high words
    tbl.push_back(mk(0, 0, 0, 0, 1,         'h1000, 0, NOOP, 'h0, 'h0, 0));
    tbl.push_back(mk(0, 1, 0, 0, 0,         'h1000, 1, CD, 'h1000, 'h1004, 0));
    tbl.push_back(mk(0, 1, 0, 0, 1,         'h1008, 1, AB, 'h1004, 'h1008, 0));
    tbl.push_back(mk(0, 1, 0, 0, 0,         'h1008, 1, AB, 'h1004, 'h1008, 0));
    tbl.push_back(mk(0, 1, 0, 0, 0,         'h1010, 1, AB, 'h1004, 'h1008, 0));
    // reset mid-stream with three entries queued
    tbl.push_back(mk(1, 1, 0, 0, 1,         'h0,    0, NOOP, 'h0, 'h0, 0));
    // cache miss held at 0x20
    tbl.push_back(mk(0, 0, 1, 'h20, 0,      'h20,   0, NOOP, 'h0, 'h0, 0));
    tbl.push_back(mk(0, 0, 0, 0, 0,         'h20,   0, NOOP, 'h0, 'h0, 0));
    tbl.push_back(mk(0, 0, 0, 0, 0,         'h20,   0, NOOP, 'h0, 'h0, 0));
    tbl.push_back(mk(0, 0, 0, 0, 0,         'h20,   0, NOOP, 'h0, 'h0, 0));
    tbl.push_back(mk(0, 1, 0, 0, 0,         'h20,   1, CD, 'h20, 'h24, 0));
    // back-to-back rollbacks: last one wins
    tbl.push_back(mk(0, 1, 1, 'h500, 1,     'h500,  0, NOOP, 'h0, 'h0, 0));
    tbl.push_back(mk(0, 1, 1, 'h777, 1,     'h770,  0, NOOP, 'h0, 'h0, 0));
    tbl.push_back(mk(0, 1, 0, 0, 0,         'h778,  1, AB, 'h774, 'h778, 0));
    // PC wrap at 2^64
    tbl.push_back(mk(0, 0, 1, 64'hFFFF_FFFF_FFFF_FFFE, 0,
                     64'hFFFF_FFFF_FFFF_FFF8, 0, NOOP, 'h0, 'h0, 0));
    tbl.push_back(mk(0, 1, 0, 0, 0,         'h0,    1, AB,
                     64'hFFFF_FFFF_FFFF_FFFC, 'h0, 0));

    for (int i = 0; i < tbl.size(); i++) begin
      cycle(tbl[i].rst, tbl[i].vld, tbl[i].data, tbl[i].rb, tbl[i].tpc, tbl[i].de);
      chk($sformatf("tbl%0d_addr", i),  proc2Icache_addr, tbl[i].e_addr);
      chk($sformatf("tbl%0d_valid", i), 64'(if_valid), 64'(tbl[i].e_valid));
      chk($sformatf("tbl%0d_inst", i),  64'(if_inst), 64'(tbl[i].e_inst));
      chk($sformatf("tbl%0d_pc", i),    if_PC, tbl[i].e_pc);
      chk($sformatf("tbl%0d_npc", i),   if_NPC, tbl[i].e_npc);
      chk($sformatf("tbl%0d_full", i),  64'(fq_full), 64'(tbl[i].e_full));
    end

    // Random traffic: mostly fetching, occasional rollbacks and resets.
    for (int i = 0; i < 800; i++) begin
      logic        r_rst, r_vld, r_rb, r_de;
      logic [63:0] r_data, r_tpc;
      r_rst  = ($urandom_range(0, 99) == 0);
      r_vld  = ($urandom_range(0, 9) < 7);
      r_rb   = ($urandom_range(0, 29) == 0);
      r_de   = ($urandom_range(0, 9) < 4);
      r_data = {$urandom, $urandom};
      r_tpc  = ($urandom_range(0, 3) == 0) ? (64'hFFFF_FFFF_FFFF_FFF0 | 64'($urandom_range(0, 15)))
                                           : {$urandom, $urandom};
      cycle(r_rst, r_vld, r_data, r_rb, r_tpc, r_de);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
